// File: rtl/decode_issue_stage_pkg.sv
// Shared opcode and decode-state definitions for the decode/issue stage.
package decode_issue_stage_pkg;

    typedef enum logic [2:0] {AND, LSH, RSH, XOR, LD, SW, BNE, EXT} op_mne;

    localparam logic [2:0] kAND = 3'b000;
    localparam logic [2:0] kLSH = 3'b001;
    localparam logic [2:0] kRSH = 3'b010;
    localparam logic [2:0] kXOR = 3'b011;
    localparam logic [2:0] kLD  = 3'b100;
    localparam logic [2:0] kSW  = 3'b101;
    localparam logic [2:0] kBNE = 3'b110;
    localparam logic [2:0] kEXT = 3'b111;

    typedef enum logic {IDLE, PREFIX} decState_e;

endpackage

// File: rtl/decode_issue_stage_load_use_tracker.sv
// Remembers the destination of the most recent load and flags a load-use hazard
// against the word currently offered by fetch.
module load_use_tracker #(
    parameter int RAW = 3
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           flush,
    input  logic           accept,
    input  logic           acceptPrefix,
    input  logic           isLoad,
    input  logic           inValid,
    input  logic [RAW-1:0] inRd,
    input  logic [RAW-1:0] inRs,
    input  logic           checkRd,
    output logic           hazard
);

    logic           trackValid;
    logic [RAW-1:0] trackRd;

    assign hazard = trackValid & inValid &
                    ((inRs == trackRd) | (checkRd & (inRd == trackRd)));

    // A hazard blocks acceptance, so clearing here bounds the bubble to one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            trackValid <= 1'b0;
            trackRd    <= '0;
        end else if (flush | hazard) begin
            trackValid <= 1'b0;
        end else if (accept & ~acceptPrefix) begin
            trackValid <= isLoad;
            trackRd    <= inRd;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: splits instruction words into fields behind a valid/ready
// handshake, merges EXT-prefixed pairs, and inserts load-use bubbles.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int OPW    = 3,
    parameter int RAW    = 3,
    parameter int IW     = OPW + 2*RAW,
    parameter int EXT_EN = 1,
    parameter int CW     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_op,
    output logic [RAW-1:0]   out_rd,
    output logic [RAW-1:0]   out_rs,
    output logic             out_ext,
    output logic [4*RAW-1:0] out_imm,
    output logic             out_illegal,
    output logic [CW-1:0]    stall_cnt
);

    logic [OPW-1:0]   inOp;
    logic [RAW-1:0]   inRd;
    logic [RAW-1:0]   inRs;
    logic [2*RAW-1:0] inLow;
    logic             isExtOp;
    logic             isLoad;
    logic             checkRd;
    logic             hazard;
    logic             accept;
    logic             prefixWord;
    logic             issueExt;
    logic             issueIllegal;
    logic [2*RAW-1:0] prefixBits;
    decState_e        state;
    decState_e        stateNext;

    assign inOp    = in_instr[IW-1 -: OPW];
    assign inRd    = in_instr[2*RAW-1 -: RAW];
    assign inRs    = in_instr[RAW-1:0];
    assign inLow   = in_instr[2*RAW-1:0];
    assign isExtOp = (inOp == OPW'(kEXT));
    assign isLoad  = (inOp == OPW'(kLD));
    assign checkRd = (inOp == OPW'(kSW)) | (inOp == OPW'(kBNE));

    assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    load_use_tracker #(.RAW(RAW)) tracker (
        .Clk          (Clk),
        .Reset        (Reset),
        .flush        (flush),
        .accept       (accept),
        .acceptPrefix (prefixWord),
        .isLoad       (isLoad),
        .inValid      (in_valid),
        .inRd         (inRd),
        .inRs         (inRs),
        .checkRd      (checkRd),
        .hazard       (hazard)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Classification of the offered word depends only on the word and the state.
    always_comb begin
        stateNext    = state;
        prefixWord   = 1'b0;
        issueExt     = 1'b0;
        issueIllegal = 1'b0;
        case (state)
            IDLE: begin
                if (isExtOp) begin
                    prefixWord   = (EXT_EN != 0);
                    issueIllegal = (EXT_EN == 0);
                end
                if (accept & prefixWord) stateNext = PREFIX;
            end
            PREFIX: begin
                issueIllegal = isExtOp;
                issueExt     = ~isExtOp;
                if (accept) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (flush) stateNext = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) prefixBits <= '0;
        else if (accept & prefixWord) prefixBits <= inLow;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid   <= 1'b0;
            out_op      <= '0;
            out_rd      <= '0;
            out_rs      <= '0;
            out_ext     <= 1'b0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept & ~prefixWord) begin
            out_valid   <= 1'b1;
            out_op      <= inOp;
            out_rd      <= inRd;
            out_rs      <= inRs;
            out_ext     <= issueExt;
            out_imm     <= issueExt ? {prefixBits, inLow} : '0;
            out_illegal <= issueIllegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) stall_cnt <= '0;
        else if (hazard & ~flush & ~(&stall_cnt)) stall_cnt <= stall_cnt + CW'(1);
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomized and directed bench for decode_issue_stage; two instances (default and
// EXT_EN=0/CW=2) share stimulus and are checked against a transaction-level model.
module tb_decode_issue_stage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [8:0]  in_instr = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        inReady[2];
    logic        outValid[2];
    logic        outExt[2];
    logic        outIllegal[2];
    logic [2:0]  outOp[2];
    logic [2:0]  outRd[2];
    logic [2:0]  outRs[2];
    logic [11:0] outImm[2];
    logic [15:0] stallCnt0;
    logic [1:0]  stallCnt1;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 0;

    always #5 Clk = ~Clk;

    decode_issue_stage u0 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(inReady[0]),
        .in_instr(in_instr), .flush(flush), .out_valid(outValid[0]), .out_ready(out_ready),
        .out_op(outOp[0]), .out_rd(outRd[0]), .out_rs(outRs[0]), .out_ext(outExt[0]),
        .out_imm(outImm[0]), .out_illegal(outIllegal[0]), .stall_cnt(stallCnt0)
    );

    decode_issue_stage #(.EXT_EN(0), .CW(2)) u1 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(inReady[1]),
        .in_instr(in_instr), .flush(flush), .out_valid(outValid[1]), .out_ready(out_ready),
        .out_op(outOp[1]), .out_rd(outRd[1]), .out_rs(outRs[1]), .out_ext(outExt[1]),
        .out_imm(outImm[1]), .out_illegal(outIllegal[1]), .stall_cnt(stallCnt1)
    );

    // Reference model: one record per instance, advanced once per clock edge.
    bit         mValid[2];
    logic [2:0] mOp[2];
    logic [2:0] mRd[2];
    logic [2:0] mRs[2];
    bit         mExt[2];
    logic [11:0] mImm[2];
    bit         mIll[2];
    int         mCnt[2];
    bit         mPend[2];
    logic [5:0] mPre[2];
    bit         mLdV[2];
    logic [2:0] mLdRd[2];
    int         extEnOf[2] = '{1, 0};
    int         cntMax[2]  = '{65535, 3};

    function automatic bit modelHazard(int k);
        logic [2:0] op = in_instr[8:6];
        return mLdV[k] && in_valid &&
               (in_instr[2:0] == mLdRd[k] ||
                ((op == 3'd5 || op == 3'd6) && in_instr[5:3] == mLdRd[k]));
    endfunction

    function automatic bit modelReady(int k);
        return !flush && !modelHazard(k) && (!mValid[k] || out_ready);
    endfunction

    task automatic modelStep(int k);
        bit hz;
        bit acc;
        logic [2:0] op;
        op = in_instr[8:6];
        if (Reset) begin
            mValid[k] = 0; mOp[k] = 0; mRd[k] = 0; mRs[k] = 0; mExt[k] = 0;
            mImm[k] = 0; mIll[k] = 0; mCnt[k] = 0; mPend[k] = 0; mPre[k] = 0;
            mLdV[k] = 0; mLdRd[k] = 0;
            return;
        end
        if (flush) begin
            mValid[k] = 0; mPend[k] = 0; mLdV[k] = 0;
            return;
        end
        hz  = modelHazard(k);
        acc = in_valid && modelReady(k);
        if (hz) begin
            mLdV[k] = 0;
            if (mCnt[k] < cntMax[k]) mCnt[k]++;
        end
        if (mValid[k] && out_ready) mValid[k] = 0;
        if (acc) begin
            if (!mPend[k] && op == 3'd7 && extEnOf[k] != 0) begin
                mPend[k] = 1;
                mPre[k]  = in_instr[5:0];
            end else begin
                mValid[k] = 1;
                mOp[k]    = op;
                mRd[k]    = in_instr[5:3];
                mRs[k]    = in_instr[2:0];
                mExt[k]   = mPend[k] && op != 3'd7;
                mImm[k]   = mExt[k] ? {mPre[k], in_instr[5:0]} : 12'd0;
                mIll[k]   = (op == 3'd7);
                mPend[k]  = 0;
                mLdV[k]   = (op == 3'd4);
                mLdRd[k]  = in_instr[5:3];
            end
        end
    endtask

    always @(posedge Clk) begin
        for (int k = 0; k < 2; k++) modelStep(k);
    end

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s dut%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (cmpEn) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput("in_ready", k, 32'(inReady[k]), 32'(modelReady(k)));
                checkOutput("out_valid", k, 32'(outValid[k]), 32'(mValid[k]));
                checkOutput("stall_cnt", k, (k == 0) ? 32'(stallCnt0) : 32'(stallCnt1),
                            32'(mCnt[k]));
                if (mValid[k]) begin
                    checkOutput("out_op", k, 32'(outOp[k]), 32'(mOp[k]));
                    checkOutput("out_rd", k, 32'(outRd[k]), 32'(mRd[k]));
                    checkOutput("out_rs", k, 32'(outRs[k]), 32'(mRs[k]));
                    checkOutput("out_ext", k, 32'(outExt[k]), 32'(mExt[k]));
                    checkOutput("out_imm", k, 32'(outImm[k]), 32'(mImm[k]));
                    checkOutput("out_illegal", k, 32'(outIllegal[k]), 32'(mIll[k]));
                end
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic v, input logic [8:0] instr,
                                 input logic fl, input logic rdy);
        @(posedge Clk);
        #1;
        Reset     = rst;
        in_valid  = v;
        in_instr  = instr;
        flush     = fl;
        out_ready = rdy;
    endtask

    task automatic expectWord(input string name, input int k, input logic [2:0] op,
                              input logic [2:0] rd, input logic [2:0] rs, input logic ext,
                              input logic [11:0] imm, input logic ill);
        checkOutput({name, "_valid"}, k, 32'(outValid[k]), 32'd1);
        checkOutput({name, "_op"}, k, 32'(outOp[k]), 32'(op));
        checkOutput({name, "_rd"}, k, 32'(outRd[k]), 32'(rd));
        checkOutput({name, "_rs"}, k, 32'(outRs[k]), 32'(rs));
        checkOutput({name, "_ext"}, k, 32'(outExt[k]), 32'(ext));
        checkOutput({name, "_imm"}, k, 32'(outImm[k]), 32'(imm));
        checkOutput({name, "_illegal"}, k, 32'(outIllegal[k]), 32'(ill));
    endtask

    initial begin
        applyStimulus(1, 0, 9'd0, 0, 1);
        applyStimulus(0, 0, 9'd0, 0, 1);
        cmpEn = 1;
        @(negedge Clk);
        checkOutput("rst_valid", 0, 32'(outValid[0]), 32'd0);
        checkOutput("rst_fields", 0, {outOp[0], outRd[0], outRs[0], outImm[0]}, 32'd0);
        checkOutput("rst_flags", 0, {outExt[0], outIllegal[0]}, 32'd0);
        checkOutput("rst_stall", 0, 32'(stallCnt0), 32'd0);

        // XOR r2,r5
        applyStimulus(0, 1, 9'b011_010_101, 0, 1);
        applyStimulus(0, 0, 9'd0, 0, 1);
        @(negedge Clk);
        expectWord("t1", 0, 3'd3, 3'd2, 3'd5, 0, 12'd0, 0);

        // LD r3,r1 then dependent AND r0,r3
        applyStimulus(0, 1, 9'b100_011_001, 0, 1);
        applyStimulus(0, 1, 9'b000_000_011, 0, 1);
        @(negedge Clk);
        checkOutput("t2_ready_hazard", 0, 32'(inReady[0]), 32'd0);
        applyStimulus(0, 1, 9'b000_000_011, 0, 1);
        @(negedge Clk);
        checkOutput("t2_bubble", 0, 32'(outValid[0]), 32'd0);
        checkOutput("t2_stall", 0, 32'(stallCnt0), 32'd1);
        applyStimulus(0, 0, 9'd0, 0, 1);
        @(negedge Clk);
        expectWord("t2", 0, 3'd0, 3'd0, 3'd3, 0, 12'd0, 0);

        // EXT prefix followed by SW
        applyStimulus(0, 1, 9'b111_101_011, 0, 1);
        applyStimulus(0, 1, 9'b101_001_010, 0, 1);
        @(negedge Clk);
        checkOutput("t3_no_prefix_out", 0, 32'(outValid[0]), 32'd0);
        applyStimulus(0, 0, 9'd0, 0, 1);
        @(negedge Clk);
        expectWord("t3", 0, 3'd5, 3'd1, 3'd2, 1, 12'b101011_001010, 0);

        // EXT then flush, then LSH decodes standalone
        applyStimulus(0, 1, 9'b111_110_110, 0, 1);
        applyStimulus(0, 0, 9'd0, 1, 1);
        @(negedge Clk);
        checkOutput("t4_ready_flush", 0, 32'(inReady[0]), 32'd0);
        applyStimulus(0, 1, 9'b001_010_011, 0, 1);
        @(negedge Clk);
        checkOutput("t4_flushed", 0, 32'(outValid[0]), 32'd0);
        applyStimulus(0, 0, 9'd0, 0, 1);
        @(negedge Clk);
        expectWord("t4", 0, 3'd1, 3'd2, 3'd3, 0, 12'd0, 0);

        // Backpressure: RSH held while XOR waits
        applyStimulus(0, 1, 9'b010_001_001, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 9'b011_110_111, 0, 0);
            @(negedge Clk);
            expectWord("t5_hold", 0, 3'd2, 3'd1, 3'd1, 0, 12'd0, 0);
            checkOutput("t5_ready_hold", 0, 32'(inReady[0]), 32'd0);
        end
        applyStimulus(0, 1, 9'b011_110_111, 0, 1);
        @(negedge Clk);
        checkOutput("t5_ready_release", 0, 32'(inReady[0]), 32'd1);
        applyStimulus(0, 0, 9'd0, 0, 1);
        @(negedge Clk);
        expectWord("t5", 0, 3'd3, 3'd6, 3'd7, 0, 12'd0, 0);

        // Reset while a prefix is pending
        applyStimulus(0, 1, 9'b111_010_010, 0, 1);
        applyStimulus(1, 0, 9'd0, 0, 1);
        applyStimulus(0, 1, 9'b011_001_100, 0, 1);
        applyStimulus(0, 0, 9'd0, 0, 1);
        @(negedge Clk);
        expectWord("t7", 0, 3'd3, 3'd1, 3'd4, 0, 12'd0, 0);

        // EXT_EN=0 illegal opcode, then counter saturation
        applyStimulus(1, 0, 9'd0, 0, 1);
        applyStimulus(0, 1, 9'b111_000_000, 0, 1);
        applyStimulus(0, 0, 9'd0, 0, 1);
        @(negedge Clk);
        expectWord("t6_illegal", 1, 3'd7, 3'd0, 3'd0, 0, 12'd0, 1);
        checkOutput("t6_prefix_silent", 0, 32'(outValid[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 9'b100_001_001, 0, 1);
            applyStimulus(0, 1, 9'b000_000_001, 0, 1);
            applyStimulus(0, 1, 9'b000_000_001, 0, 1);
        end
        applyStimulus(0, 0, 9'd0, 0, 1);
        @(negedge Clk);
        checkOutput("t6_sat", 1, 32'(stallCnt1), 32'd3);
        checkOutput("t6_count", 0, 32'(stallCnt0), 32'd4);

        // Randomized traffic with narrow register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 256) == 0, ($urandom % 4) != 0,
                          {3'($urandom % 8), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))},
                          ($urandom % 16) == 0, ($urandom % 4) != 0);
        end
        applyStimulus(0, 0, 9'd0, 0, 1);
        applyStimulus(0, 0, 9'd0, 0, 1);
        @(negedge Clk);
        cmpEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
